mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe.sv | 140 ++++++++++++++
 tb/tb_mux_n_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-way registered multiplexer behind a two-entry skid buffer (valid/ready on both sides).
// Out-of-range selects yield a zero beat flagged by out_sel_err and are tallied in err_count.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = $clog2(N),
  parameter int CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]   sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_sel_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic [CNTW-1:0]   err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_reg, state_next;
  logic             in_ready_reg;
  logic [WIDTH-1:0] main_data_reg, skid_data_reg;
  logic             main_err_reg, skid_err_reg;
  logic [CNTW-1:0]  err_count_reg, err_count_next;

  logic [WIDTH-1:0] d_arr [N];
  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic             accept, consume;
  logic             load_main, load_skid, main_from_skid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign d_arr[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Any select value not matched below is out of range: zero data, error flag.
  always_comb begin
    beat_data = '0;
    beat_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        beat_data = d_arr[k];
        beat_err  = 1'b0;
      end
    end
  end

  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;
  assign accept    = in_valid && in_ready_reg;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (!accept && consume) begin
          state_next = EMPTY;
        end else if (accept && consume) begin
          load_main  = 1'b1;
        end
      end
      TWO: begin
        if (consume) begin
          state_next     = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Registered ready tracks the state we are about to enter.
      in_ready_reg <= (state_next != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_reg <= '0;
      main_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data_reg <= beat_data;
        main_err_reg  <= beat_err;
      end else if (main_from_skid) begin
        main_data_reg <= skid_data_reg;
        main_err_reg  <= skid_err_reg;
      end
      if (load_skid) begin
        skid_data_reg <= beat_data;
        skid_err_reg  <= beat_err;
      end
    end
  end

  // Clear takes effect first so a same-cycle counted beat lands on 1.
  always_comb begin
    err_count_next = err_clr ? '0 : err_count_reg;
    if (accept && beat_err && !(&err_count_next))
      err_count_next = err_count_next + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_reg <= '0;
    else        err_count_reg <= err_count_next;
  end

  assign out_data    = main_data_reg;
  assign out_sel_err = main_err_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and randomized checks of mux_n_pipe with N=3, WIDTH=32, CNTW=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mux_n_pipe;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int SELW  = 2;
  localparam int CNTW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*WIDTH-1:0] d;
  logic [SELW-1:0]   sel;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_sel_err;
  logic              out_valid;
  logic              out_ready;
  logic              err_clr;
  logic [CNTW-1:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(WIDTH), .N(N), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr),
    .err_count(err_count)
  );

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    sel = '0; d = {32'h33, 32'h22, 32'h11};
    repeat (2) cycle();
    n_checks++;
    if ({in_ready, out_valid, out_sel_err, out_data, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b err=%0b data=%h cnt=%0d, want all 0",
               in_ready, out_valid, out_sel_err, out_data, err_count);
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%0b vld=%0b, want rdy=1 vld=0", in_ready, out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    d = {32'h33, 32'h22, 32'h11};
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h22 || out_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sel1: got vld=%0b data=%h err=%0b, want vld=1 data=00000022 err=0",
               out_valid, out_data, out_sel_err);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got vld=%0b, want 0", out_valid);
    end
    $display("test_basic done");
  endtask

  task automatic test_sel_err();
    bit ready_ok = 1'b1;
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== '0 || out_sel_err !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL sel_err_first: got vld=%0b data=%h err=%0b cnt=%0d, want 1 0 1 1",
               out_valid, out_data, out_sel_err, err_count);
    end
    for (int i = 0; i < 299; i++) begin
      if (in_ready !== 1'b1) ready_ok = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ready_ok) begin
      n_fail++;
      $display("FAIL throughput: in_ready got 0 during streaming, want 1");
    end
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d, want 255", err_count);
    end
    idle();
    $display("test_sel_err done");
  endtask

  task automatic test_back_to_back();
    d = {32'h33, 32'h22, 32'h11};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    cycle();
    sel = 2'd1;
    cycle();
    sel = 2'd2;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin
      n_fail++;
      $display("FAIL b2b_full: got rdy=%0b vld=%0b data=%h, want rdy=0 vld=1 data=00000011",
               in_ready, out_valid, out_data);
    end
    cycle();
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h11 || out_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: got rdy=%0b data=%h err=%0b, want rdy=0 data=00000011 err=0",
               in_ready, out_data, out_sel_err);
    end
    out_ready = 1'b1;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h22 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got vld=%0b data=%h rdy=%0b, want vld=1 data=00000022 rdy=1",
               out_valid, out_data, in_ready);
    end
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h33) begin
      n_fail++;
      $display("FAIL b2b_third: got vld=%0b data=%h, want vld=1 data=00000033", out_valid, out_data);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got vld=%0b, want 0", out_valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_err_clr();
    out_ready = 1'b1; in_valid = 1'b0; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_clr_only: got %0d, want 0", err_count);
    end
    sel = 2'd3; in_valid = 1'b1;
    repeat (7) cycle();
    in_valid = 1'b0;
    cycle();
    n_checks++;
    if (err_count !== 8'd7) begin
      n_fail++;
      $display("FAIL err_count7: got %0d, want 7", err_count);
    end
    sel = 2'd2; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (err_count !== 8'd7) begin
      n_fail++;
      $display("FAIL err_inrange: got %0d, want 7", err_count);
    end
    sel = 2'd3; in_valid = 1'b1; err_clr = 1'b1;
    cycle();
    in_valid = 1'b0; err_clr = 1'b0;
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_clr_and_count: got %0d, want 1", err_count);
    end
    idle();
    $display("test_err_clr done");
  endtask

  task automatic test_reset_two();
    d = {32'h33, 32'h22, 32'h11};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    cycle();
    sel = 2'd1;
    cycle();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got vld=%0b rdy=%0b data=%h, want 0 0 0", out_valid, in_ready, out_data);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held: got vld=%0b rdy=%0b, want 0 0", out_valid, in_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got rdy=%0b vld=%0b, want rdy=1 vld=0", in_ready, out_valid);
    end
    repeat (3) cycle();
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL rst_no_stale: got vld=%0b cnt=%0d, want vld=0 cnt=0", out_valid, err_count);
    end
    $display("test_reset_two done");
  endtask

  task automatic test_random();
    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] exp_beat;
    logic [WIDTH-1:0] din [N];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int bad = 0;
    while ((sent < 10000 || exp_q.size() > 0) && cyc < 80000) begin
      for (int k = 0; k < N; k++) din[k] = $urandom;
      d = {din[2], din[1], din[0]};
      sel = 2'($urandom_range(0, 3));
      in_valid  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_beat = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b0, {WIDTH{1'bx}}};
        got++;
        n_checks++;
        if ({out_sel_err, out_data} !== exp_beat) begin
          n_fail++;
          bad++;
          if (bad < 10)
            $display("FAIL random_beat %0d: got err=%0b data=%h, want err=%0b data=%h",
                     got, out_sel_err, out_data, exp_beat[WIDTH], exp_beat[WIDTH-1:0]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back((sel < 2'd3) ? {1'b0, din[sel]} : {1'b1, {WIDTH{1'b0}}});
        sent++;
      end
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== 10000 || exp_q.size() !== 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_total: got %0d beats, %0d pending, vld=%0b after %0d cycles, want 10000 0 0",
               got, exp_q.size(), out_valid, cyc);
    end
    $display("test_random done: %0d beats in %0d cycles", got, cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_err();
    test_back_to_back();
    test_err_clr();
    test_reset_two();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
